// File: rtl/adc_tone_model_if.sv
`default_nettype none
// ============================================================================
// Module   : alpaca_pkg / alpaca_data_pkt_axis
// Brief    : Complex-sample type and parallel AXI4-Stream bundle for the datapath.
// Revision : 1.0 - initial release
// ============================================================================
package alpaca_pkg;
    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } cx_t;
endpackage

interface alpaca_data_pkt_axis #(
    parameter int SAMP_PER_CLK = 2,
    parameter int TUSER        = 1
);
    alpaca_pkg::cx_t [SAMP_PER_CLK-1:0] tdata;
    logic                               tvalid;
    logic                               tready;
    logic                               tlast;
    logic [TUSER-1:0]                   tuser;

    modport MST (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport SLV (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface
`default_nettype wire

// File: rtl/adc_tone_model.sv
`default_nettype none
// ============================================================================
// Module   : adc_tone_model
// Brief    : Quantized complex-tone source, SAMP_PER_CLK samples per AXIS beat.
// Revision : 1.0 - initial release
// ============================================================================
module adc_tone_model #(
    parameter real PERIOD     = 10.0,
    parameter real GAIN       = 1.0,
    parameter int  BITS       = 12,
    parameter real F_SOI_NORM = 0.27
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              en,
    alpaca_data_pkt_axis.MST       m_axis
);
    import alpaca_pkg::*;

    localparam int  SPC    = m_axis.SAMP_PER_CLK;
    localparam real TWO_PI = 6.283185307179586;
    localparam real FS_R   = real'((1 << (BITS - 1)) - 1);
    localparam real MAX_R  = FS_R;
    localparam real MIN_R  = -FS_R - 1.0;

    // Split the rounded increment into 16-bit halves so no real->int step exceeds 32 bits.
    localparam real         INC_R    = $floor(F_SOI_NORM * 4294967296.0 + 0.5);
    localparam real         INC_HI_R = $floor(INC_R / 65536.0);
    localparam int          INC_HI   = $rtoi(INC_HI_R);
    localparam int          INC_LO   = $rtoi(INC_R - INC_HI_R * 65536.0);
    localparam logic [31:0] INC      = (32'(INC_HI) << 16) | 32'(INC_LO);
    localparam logic [31:0] STEP     = INC * 32'(SPC);

    if (BITS < 2 || BITS > 16) begin : g_chk_bits
        $error("adc_tone_model: BITS must lie in [2,16]");
    end
    if (PERIOD <= 0.0) begin : g_chk_period
        $error("adc_tone_model: PERIOD must be positive");
    end

    logic signed [BITS-1:0] cos_lut [1024];

    for (genvar k = 0; k < 1024; k++) begin : g_lut
        localparam real AMP = GAIN * FS_R * $cos(TWO_PI * real'(k) / 1024.0);
        localparam real SAT = (AMP > MAX_R) ? MAX_R : ((AMP < MIN_R) ? MIN_R : AMP);
        localparam int  VAL = $rtoi($floor(SAT + 0.5));
        assign cos_lut[k] = BITS'(VAL);
    end

    logic [31:0]        acc_q,    acc_d;
    logic               tvalid_q, tvalid_d;
    cx_t  [SPC-1:0]     tdata_q,  tdata_d;
    cx_t  [SPC-1:0]     beat_next;
    logic               beat_load;

    // Sin shares the cos table: sin(x) = cos(x - pi/2), i.e. index + 768 mod 1024.
    for (genvar l = 0; l < SPC; l++) begin : g_lane
        localparam logic [31:0] LANE_OFS = INC * 32'(l);
        logic [9:0] idx_cos;
        logic [9:0] idx_sin;
        assign idx_cos      = 10'((acc_q + LANE_OFS) >> 22);
        assign idx_sin      = idx_cos + 10'd768;
        assign beat_next[l] = {16'(cos_lut[idx_cos]), 16'(cos_lut[idx_sin])};
    end

    assign beat_load = en && (!tvalid_q || m_axis.tready);

    always_comb begin
        acc_d    = acc_q;
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        if (beat_load) begin
            acc_d    = acc_q + STEP;
            tvalid_d = 1'b1;
            tdata_d  = beat_next;
        end else if (m_axis.tready) begin
            tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= '0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
        end else begin
            acc_q    <= acc_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
        end
    end

    assign m_axis.tdata  = tdata_q;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = 1'b0;
    assign m_axis.tuser  = '0;

endmodule
`default_nettype wire

// File: tb/tb_adc_tone_model.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_tone_model
// Brief    : Self-checking bench: quarter-rate tone stream and saturated DC tone.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_tone_model;
    import alpaca_pkg::*;

    localparam int SPC = 2;

    typedef struct {
        logic [15:0] re;
        logic [15:0] im;
    } samp_t;

    typedef struct {
        logic en;
        logic tready;
        logic exp_valid;
        logic hold;
    } vec_t;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic en   = 1'b0;
    logic en_s = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    samp_t       tone [4];
    vec_t        vecs [20];
    logic [63:0] exp_q [$];
    logic [63:0] prev;
    logic [63:0] sat_exp;

    always #5 clk = ~clk;

    alpaca_data_pkt_axis #(.SAMP_PER_CLK(SPC), .TUSER(1)) axis_q ();
    alpaca_data_pkt_axis #(.SAMP_PER_CLK(SPC), .TUSER(1)) axis_s ();

    adc_tone_model #(
        .PERIOD(10.0), .GAIN(1.0), .BITS(12), .F_SOI_NORM(0.25)
    ) dut_q (
        .clk(clk), .rst(rst), .en(en), .m_axis(axis_q)
    );

    adc_tone_model #(
        .PERIOD(10.0), .GAIN(1.5), .BITS(12), .F_SOI_NORM(0.0)
    ) dut_s (
        .clk(clk), .rst(rst), .en(en_s), .m_axis(axis_s)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Sample n of a quarter-rate tone cycles through 4 values; lane 0 sits in the low word.
    function automatic logic [63:0] exp_beat(input int b);
        logic [63:0] r;
        samp_t       s;
        r = '0;
        for (int l = 0; l < SPC; l++) begin
            s = tone[(SPC * b + l) % 4];
            r[l*32 +: 32] = {s.re, s.im};
        end
        return r;
    endfunction

    task automatic step(input logic en_v, input logic tr_v);
        logic        xfer;
        logic [63:0] beat;
        en            = en_v;
        axis_q.tready = tr_v;
        #1;
        xfer = axis_q.tvalid && tr_v;
        beat = axis_q.tdata;
        @(posedge clk);
        if (xfer) begin
            if (exp_q.size() == 0) check("sb_underflow", 64'd1, 64'd0);
            else                   check("sb_beat", beat, exp_q.pop_front());
        end
        @(negedge clk);
    endtask

    initial begin
        tone[0] = '{16'h07FF, 16'h0000};
        tone[1] = '{16'h0000, 16'h07FF};
        tone[2] = '{16'hF801, 16'h0000};
        tone[3] = '{16'h0000, 16'hF801};
        sat_exp = {16'h07FF, 16'h0000, 16'h07FF, 16'h0000};

        vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 3; i < 10; i++) vecs[i] = '{1'b1, 1'b0, 1'b1, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b1};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 1'b1, 1'b0};
        vecs[17] = '{1'b1, 1'b1, 1'b1, 1'b0};
        vecs[18] = '{1'b1, 1'b1, 1'b1, 1'b0};
        vecs[19] = '{1'b1, 1'b1, 1'b1, 1'b0};

        en            = 1'b1;
        axis_q.tready = 1'b1;
        axis_s.tready = 1'b1;
        rst           = 1'b1;

        repeat (3) begin
            @(negedge clk);
            check("reset_tvalid", 64'(axis_q.tvalid), 64'd0);
        end
        check("reset_tdata", axis_q.tdata, 64'd0);
        check("reset_tlast", 64'(axis_q.tlast), 64'd0);
        check("reset_tuser", 64'(axis_q.tuser), 64'd0);

        for (int b = 0; b < 9; b++) exp_q.push_back(exp_beat(b));
        rst = 1'b0;
        step(1'b1, 1'b1);
        check("first_tvalid", 64'(axis_q.tvalid), 64'd1);
        check("first_beat", axis_q.tdata, exp_beat(0));

        prev = axis_q.tdata;
        for (int i = 0; i < 20; i++) begin
            step(vecs[i].en, vecs[i].tready);
            check($sformatf("vec%0d_tvalid", i), 64'(axis_q.tvalid), 64'(vecs[i].exp_valid));
            if (vecs[i].hold) check($sformatf("vec%0d_hold", i), axis_q.tdata, prev);
            prev = axis_q.tdata;
        end
        check("sb_drained", 64'(exp_q.size()), 64'd0);
        check("next_beat", axis_q.tdata, exp_beat(9));

        rst = 1'b1;
        #1;
        check("midrst_tvalid", 64'(axis_q.tvalid), 64'd0);
        check("midrst_tdata", axis_q.tdata, 64'd0);
        exp_q.delete();
        for (int b = 0; b < 4; b++) exp_q.push_back(exp_beat(b));
        @(negedge clk);
        check("midrst_hold_tvalid", 64'(axis_q.tvalid), 64'd0);
        rst = 1'b0;
        step(1'b1, 1'b1);
        check("restart_tvalid", 64'(axis_q.tvalid), 64'd1);
        check("restart_beat", axis_q.tdata, exp_beat(0));
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1);
            check("restart_stream_tvalid", 64'(axis_q.tvalid), 64'd1);
        end
        check("restart_sb_drained", 64'(exp_q.size()), 64'd0);

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("sat_tvalid", 64'(axis_s.tvalid), 64'd1);
            check("sat_beat", axis_s.tdata, sat_exp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
